// File: rtl/instr_imm_packer.sv
// rtl/instr_imm_packer.sv - range-checks an immediate against its opcode class and packs fields into an instruction word
module instr_imm_packer #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_STEP = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [2:0]  in_rs,
    input  logic [2:0]  in_rt,
    input  logic [2:0]  in_rd,
    input  logic [1:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic        addr_load,
    input  logic [15:0] addr_val,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic        range_err,
    output logic [7:0]  err_count,
    output logic [15:0] wr_count
);

    localparam logic [2:0] C_R   = 3'd0;
    localparam logic [2:0] C_S5  = 3'd1;
    localparam logic [2:0] C_Z5  = 3'd2;
    localparam logic [2:0] C_S8  = 3'd3;
    localparam logic [2:0] C_Z8  = 3'd4;
    localparam logic [2:0] C_S11 = 3'd5;

    logic [2:0]  cls;
    logic        legal;
    logic [15:0] packed_word;
    logic        accept;
    logic        complete;

    always_comb begin
        cls = C_R;
        case (in_op)
            5'b01000, 5'b01001, 5'b10000,
            5'b10001, 5'b10011, 5'b10100: cls = C_S5;
            5'b01010, 5'b01011:           cls = C_Z5;
            5'b01100, 5'b01101, 5'b01110,
            5'b01111, 5'b00101, 5'b00111: cls = C_S8;
            5'b10010:                     cls = C_Z8;
            5'b00100, 5'b00110:           cls = C_S11;
            default:                      cls = C_R;
        endcase
    end

    // Signed classes are legal when every bit above the field is a copy of the field's sign bit.
    always_comb begin
        legal       = 1'b1;
        packed_word = {in_op, in_rs, in_rt, in_rd, in_funct};
        case (cls)
            C_S5: begin
                legal       = (in_imm[15:4] == {12{in_imm[15]}});
                packed_word = {in_op, in_rs, in_rd, in_imm[4:0]};
            end
            C_Z5: begin
                legal       = (in_imm[15:5] == 11'd0);
                packed_word = {in_op, in_rs, in_rd, in_imm[4:0]};
            end
            C_S8: begin
                legal       = (in_imm[15:7] == {9{in_imm[15]}});
                packed_word = {in_op, in_rs, in_imm[7:0]};
            end
            C_Z8: begin
                legal       = (in_imm[15:8] == 8'd0);
                packed_word = {in_op, in_rs, in_imm[7:0]};
            end
            C_S11: begin
                legal       = (in_imm[15:10] == {6{in_imm[15]}});
                packed_word = {in_op, in_imm[10:0]};
            end
            default: begin
                legal       = 1'b1;
                packed_word = {in_op, in_rs, in_rt, in_rd, in_funct};
            end
        endcase
    end

    assign in_ready = !addr_load && (!mem_wr || mem_ready);
    assign accept   = in_valid && in_ready;
    assign complete = mem_wr && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_data  <= 16'h0000;
            range_err <= 1'b0;
            err_count <= 8'd0;
            wr_count  <= 16'd0;
        end else begin
            range_err <= accept && !legal;
            if (accept && !legal && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            if (complete)
                wr_count <= wr_count + 16'd1;

            // A load held off by a pending write lands once mem_wr has dropped.
            if (addr_load && !mem_wr)
                mem_addr <= addr_val;
            else if (complete)
                mem_addr <= mem_addr + ADDR_STEP;

            if (accept && legal) begin
                mem_wr   <= 1'b1;
                mem_data <= packed_word;
            end else if (complete) begin
                mem_wr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_imm_packer.sv
// tb/tb_instr_imm_packer.sv - directed vector bench for instr_imm_packer
module tb_instr_imm_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_funct;
    logic [15:0] in_imm;
    logic        addr_load;
    logic [15:0] addr_val;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        range_err;
    logic [7:0]  err_count;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_imm_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .addr_load (addr_load),
        .addr_val  (addr_val),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .range_err (range_err),
        .err_count (err_count),
        .wr_count  (wr_count)
    );

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [1:0]  funct;
        logic [15:0] imm;
        logic        err;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[15];

    logic        m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_wrc;
    logic [7:0]  m_errc;
    logic [15:0] hold_data, hold_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                            input logic [2:0] rd, input logic [1:0] funct, input logic [15:0] imm);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = funct; in_imm = imm;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " mem_wr"},    {31'd0, mem_wr},   {31'd0, m_wr});
        chk({tag, " mem_addr"},  {16'd0, mem_addr}, {16'd0, m_addr});
        chk({tag, " wr_count"},  {16'd0, wr_count}, {16'd0, m_wrc});
        chk({tag, " err_count"}, {24'd0, err_count}, {24'd0, m_errc});
    endtask

    initial begin
        //              op        rs    rt    rd    fn     imm       err   data
        vecs[0]  = '{5'b01000, 3'd2, 3'd0, 3'd5, 2'd0, 16'hFFFD, 1'b0, 16'h42BD};
        vecs[1]  = '{5'b01000, 3'd2, 3'd0, 3'd5, 2'd0, 16'h0010, 1'b1, 16'h0000};
        vecs[2]  = '{5'b01010, 3'd1, 3'd0, 3'd1, 2'd0, 16'hFFFF, 1'b1, 16'h0000};
        vecs[3]  = '{5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFC00, 1'b0, 16'h2400};
        vecs[4]  = '{5'b01100, 3'd1, 3'd0, 3'd0, 2'd0, 16'h007F, 1'b0, 16'h617F};
        vecs[5]  = '{5'b10010, 3'd3, 3'd0, 3'd0, 2'd0, 16'h00FF, 1'b0, 16'h93FF};
        vecs[6]  = '{5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0400, 1'b1, 16'h0000};
        vecs[7]  = '{5'b01010, 3'd7, 3'd0, 3'd0, 2'd0, 16'h001F, 1'b0, 16'h571F};
        vecs[8]  = '{5'b11011, 3'd1, 3'd2, 3'd3, 2'd2, 16'h1234, 1'b0, 16'hD94E};
        vecs[9]  = '{5'b10100, 3'd0, 3'd0, 3'd1, 2'd0, 16'hFFF0, 1'b0, 16'hA030};
        vecs[10] = '{5'b00101, 3'd4, 3'd0, 3'd0, 2'd0, 16'hFF80, 1'b0, 16'h2C80};
        vecs[11] = '{5'b00110, 3'd0, 3'd0, 3'd0, 2'd0, 16'h03FF, 1'b0, 16'h33FF};
        vecs[12] = '{5'b10010, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b1, 16'h0000};
        vecs[13] = '{5'b01111, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0080, 1'b1, 16'h0000};
        vecs[14] = '{5'b10011, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFEF, 1'b1, 16'h0000};

        rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_val = 16'h0; mem_ready = 1'b1;
        set_beat(5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        m_wr = 1'b0; m_addr = 16'h0000; m_wrc = 16'd0; m_errc = 8'd0;
        check_model("reset");
        chk("reset mem_data",  {16'd0, mem_data}, 32'h0);
        chk("reset range_err", {31'd0, range_err}, 32'h0);
        chk("reset in_ready",  {31'd0, in_ready}, 32'h1);
        @(negedge clk) rst = 1'b0;

        // Back-to-back table beats with mem_ready high.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            set_beat(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct, vecs[i].imm);
            @(posedge clk);
            if (m_wr) begin
                m_addr = m_addr + 16'd2;
                m_wrc  = m_wrc + 16'd1;
            end
            m_wr = !vecs[i].err;
            if (vecs[i].err && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
            #1;
            check_model($sformatf("vec%0d", i));
            chk($sformatf("vec%0d range_err", i), {31'd0, range_err}, {31'd0, vecs[i].err});
            if (!vecs[i].err)
                chk($sformatf("vec%0d mem_data", i), {16'd0, mem_data}, {16'd0, vecs[i].data});
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        if (m_wr) begin
            m_addr = m_addr + 16'd2;
            m_wrc  = m_wrc + 16'd1;
        end
        m_wr = 1'b0;
        #1;
        check_model("drain");
        chk("drain range_err", {31'd0, range_err}, 32'h0);

        // Saturation of err_count.
        @(negedge clk);
        in_valid = 1'b1;
        set_beat(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0100);
        repeat (256) @(posedge clk);
        @(negedge clk) in_valid = 1'b0;
        m_errc = 8'hFF;
        #1;
        check_model("saturate");

        // Backpressure: beat A stalls, beat B waits on in_valid.
        @(negedge clk);
        mem_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat(5'b01000, 3'd2, 3'd0, 3'd5, 2'd0, 16'hFFFD);
        @(posedge clk);
        #1;
        hold_addr = m_addr;
        chk("bp accept mem_wr", {31'd0, mem_wr}, 32'h1);
        chk("bp accept data",   {16'd0, mem_data}, 32'h42BD);
        @(negedge clk) set_beat(5'b10010, 3'd3, 3'd0, 3'd0, 2'd0, 16'h00FF);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp stall%0d in_ready", c), {31'd0, in_ready}, 32'h0);
            chk($sformatf("bp stall%0d mem_wr", c),   {31'd0, mem_wr}, 32'h1);
            chk($sformatf("bp stall%0d data", c),     {16'd0, mem_data}, 32'h42BD);
            chk($sformatf("bp stall%0d addr", c),     {16'd0, mem_addr}, {16'd0, hold_addr});
        end
        @(negedge clk) mem_ready = 1'b1;
        #1 chk("bp release in_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        m_addr = hold_addr + 16'd2; m_wrc = m_wrc + 16'd1; m_wr = 1'b1;
        check_model("bp release");
        chk("bp release data", {16'd0, mem_data}, 32'h93FF);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        #1;
        m_addr = m_addr + 16'd2; m_wrc = m_wrc + 16'd1; m_wr = 1'b0;
        check_model("bp drain");

        // Load 0xFFFE with a competing in_valid: the load wins.
        @(negedge clk);
        addr_load = 1'b1; addr_val = 16'hFFFE; in_valid = 1'b1;
        set_beat(5'b01100, 3'd1, 3'd0, 3'd0, 2'd0, 16'h007F);
        #1 chk("load in_ready", {31'd0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        m_addr = 16'hFFFE;
        check_model("load");
        @(negedge clk) addr_load = 1'b0;
        @(posedge clk);
        #1;
        m_wr = 1'b1;
        check_model("wrap beat1");
        chk("wrap beat1 data", {16'd0, mem_data}, 32'h617F);
        @(negedge clk) set_beat(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFC00);
        @(posedge clk);
        #1;
        m_addr = 16'h0000; m_wrc = m_wrc + 16'd1;
        check_model("wrap beat2");
        chk("wrap beat2 data", {16'd0, mem_data}, 32'h2400);

        // Load requested while the write at 0x0000 stalls.
        @(negedge clk);
        in_valid = 1'b0; mem_ready = 1'b0; addr_load = 1'b1; addr_val = 16'h1234;
        @(posedge clk);
        #1;
        check_model("held load stall");
        @(negedge clk) mem_ready = 1'b1;
        @(posedge clk);
        #1;
        m_addr = 16'h0002; m_wrc = m_wrc + 16'd1; m_wr = 1'b0;
        check_model("held load complete");
        @(posedge clk);
        #1;
        m_addr = 16'h1234;
        check_model("held load applied");
        @(negedge clk) addr_load = 1'b0;

        // Reset while a write is stalled.
        @(negedge clk);
        mem_ready = 1'b0; in_valid = 1'b1;
        set_beat(5'b01000, 3'd2, 3'd0, 3'd5, 2'd0, 16'hFFFD);
        @(posedge clk);
        #1 chk("pre-reset mem_wr", {31'd0, mem_wr}, 32'h1);
        @(negedge clk) begin rst = 1'b1; in_valid = 1'b0; end
        @(posedge clk);
        #1;
        m_wr = 1'b0; m_addr = 16'h0000; m_wrc = 16'd0; m_errc = 8'd0;
        check_model("mid-stall reset");
        chk("mid-stall reset in_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk) rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_imm_packer.md
Name: instr_imm_packer

Overview:
- Inverse of the decode-stage immediate extender: takes decoded instruction fields plus a full 16-bit immediate, range-checks the immediate against its opcode's field, and packs the fields into a 16-bit instruction word.
- Packed words are written sequentially into instruction memory over a stallable write port.
- Used by the test-program loader and the self-check harness, so that extending an encoded immediate returns the original value.

Parameters:
- BASE_ADDR, 16'h0000, write address after reset.
- ADDR_STEP, 2, address increment per completed write (byte-addressed, word-aligned).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  field beat valid
- in_ready  output  1  block can accept a beat
- in_op  input  5  opcode, placed in instr[15:11]
- in_rs  input  3  Rs field
- in_rt  input  3  Rt field
- in_rd  input  3  Rd field
- in_funct  input  2  function bits
- in_imm  input  16  full-width immediate, two's complement
- addr_load  input  1  load the write address
- addr_val  input  16  new write address
- mem_wr  output  1  write request
- mem_addr  output  16  write address
- mem_data  output  16  packed instruction
- mem_ready  input  1  memory accepts the write this cycle
- range_err  output  1  one-cycle pulse: immediate out of range, beat dropped
- err_count  output  8  saturating count of dropped beats
- wr_count  output  16  count of completed writes, wraps

Behaviour:
- Reset values: in_ready=1, mem_wr=0, mem_addr=BASE_ADDR, mem_data=0, range_err=0, err_count=0, wr_count=0.
- Reset mid-operation discards any pending write.
- Opcode classes, packed word, and legal immediate range:
  - S5 (01000, 01001, 10000, 10001, 10011, 10100): {op, rs, rd, imm[4:0]}; legal -16..15.
  - Z5 (01010, 01011): {op, rs, rd, imm[4:0]}; legal 0..31.
  - S8 (011xx, 00101, 00111): {op, rs, imm[7:0]}; legal -128..127.
  - Z8 (10010, SLBI): {op, rs, imm[7:0]}; legal 0..255.
  - S11 (00100, 00110): {op, imm[10:0]}; legal -1024..1023.
  - All other opcodes: {op, rs, rt, rd, funct}; imm ignored, never an error.
- Pipeline: one output register (pending write).
  - Accept when in_valid & in_ready.
  - Legal beat: the cycle after accept, mem_wr=1 with mem_data/mem_addr valid. Latency is 1 cycle.
- in_ready = !addr_load & (!mem_wr | mem_ready). This gives full throughput of one word per cycle while mem_ready stays high.
- mem_wr, mem_addr and mem_data hold stable while mem_wr & !mem_ready.
- Write completes on mem_wr & mem_ready. On completion:
  - mem_addr += ADDR_STEP, wrapping at 16 bits (0xFFFE -> 0x0000);
  - wr_count += 1.
- If a completion and a new accept happen in the same cycle, the new word takes the incremented address.
- Illegal beat:
  - range_err=1 in the cycle after accept;
  - no write and no address advance;
  - err_count += 1, saturating at 255;
  - any pending write still completes normally.
- addr_load:
  - honoured only when mem_wr=0; it sets mem_addr=addr_val the next cycle;
  - if mem_wr=1, the load is held off, in_ready stays 0, and the load applies on the cycle after completion (addr_val sampled then);
  - addr_load has priority over a same-cycle in_valid.
- wr_count wraps at 0xFFFF -> 0.

Test Plan:
- ADDI: op=01000, rs=2, rd=5, imm=-3 (0xFFFD), mem_ready=1 -> next cycle mem_wr=1, mem_data=0x42BD, mem_addr=0x0000; then mem_addr=0x0002, wr_count=1.
- Range errors:
  - ADDI imm=16 -> range_err pulse, no mem_wr, err_count=1, mem_addr unchanged.
  - XORI (01010) imm=-1 -> range_err, err_count=2.
  - 256 further errors -> err_count stays 255.
- Class boundaries:
  - J (00100) imm=-1024 -> 0x2400.
  - BEQZ (01100) rs=1 imm=127 -> 0x617F.
  - SLBI (10010) rs=3 imm=255 -> 0x93FF.
  - J imm=1024 -> range_err.
- Backpressure: mem_ready=0 for 3 cycles with in_valid held -> mem_data/mem_addr stable, in_ready=0. On mem_ready=1 the write completes, the next beat is accepted the same cycle, and its address is +2.
- Wrap and load: addr_load addr_val=0xFFFE, then two legal beats -> writes at 0xFFFE then 0x0000. addr_load asserted while a write is stalled -> applied only after completion.
- Reset mid-stall: rst while mem_wr=1 & mem_ready=0 -> next cycle mem_wr=0, mem_addr=BASE_ADDR, all counters 0.
